seq_div: RTL and testbench

// - Multi-cycle restoring divider: the inverse companion of the MAC unit's multiply path.
// - Accepts one dividend/divisor pair on a start pulse.
// - Iterates one quotient bit per clock.
// - Returns quotient and remainder with a done pulse.
// - Each trial subtraction is a WIDTH+1-bit ripple of fadd cells:

---
 rtl/seq_div.sv | 232 +++++++++++++++++++++++
 tb/tb_seq_div.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div.sv
// seq_div -- multi-cycle restoring divider, one quotient bit per clock.
//
// Accepts a dividend/divisor pair on a start pulse while idle, runs WIDTH
// trial-subtraction steps and returns quotient/remainder with a one-cycle
// done pulse. A zero divisor short-circuits to a one-step result
// (quotient all ones, remainder = dividend, div_by_zero set).
//
// Optional build macro: SEQ_DIV_SIGNED_EN
//   defined   -> two's complement operands/results; magnitudes are taken at the
//                accepting edge and signs applied on the final edge (same latency).
//   undefined -> unsigned only, no sign or abs logic.
//
// Parameters:
//   WIDTH        operand, quotient and remainder width (>= 2)
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        request, sampled only while busy=0
//   dividend     numerator, sampled with start
//   divisor      denominator, sampled with start
//   busy         high while a division is in progress
//   done         one-cycle pulse, results valid from this cycle
//   quotient     result, held until replaced by the next result
//   remainder    result, held until replaced by the next result
//   div_by_zero  set with done for a zero divisor, cleared on the next
//                accepted start with a nonzero divisor

// One-bit full adder; the trial subtractor is a ripple of these.
module fadd (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module seq_div #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned          CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_ZERO = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Partial remainder, already shifted and holding the next dividend bit in
    // its LSB, so the trial subtraction reads the register directly.
    logic [WIDTH:0]     rem_q, rem_d;
    // Upper bits: dividend bits not yet consumed; lower bits: quotient so far.
    logic [WIDTH-1:0]   qsh_q, qsh_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rmdr_q, rmdr_d;
    logic               dbz_q, dbz_d;
    logic               done_q, done_d;

    // Trial subtraction rem_q - {0,dvs_q}: invert divisor, carry-in 1.
    logic [WIDTH:0]     sub_b;
    logic [WIDTH:0]     trial;
    logic [WIDTH+1:0]   carry;
    logic               borrow;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   q_raw;
    logic [WIDTH-1:0]   stored_mag;
    // The kept difference is always below the divisor, so its top bit is zero.
    logic               unused_trial_msb;

    assign sub_b    = ~{1'b0, dvs_q};
    assign carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi <= WIDTH; gi++) begin : g_sub
            fadd u_fadd (
                .a    (rem_q[gi]),
                .b    (sub_b[gi]),
                .cin  (carry[gi]),
                .s    (trial[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    assign borrow           = ~carry[WIDTH+1];
    assign unused_trial_msb = trial[WIDTH];
    assign diff             = borrow ? rem_q[WIDTH-1:0] : trial[WIDTH-1:0];
    assign q_raw            = {qsh_q[WIDTH-2:0], ~borrow};
    // Dividend (magnitude) as loaded, recovered from the working registers.
    assign stored_mag       = {rem_q[0], qsh_q[WIDTH-1:1]};

    logic [WIDTH-1:0]   dvd_mag;
    logic [WIDTH-1:0]   dvs_mag;
    logic [WIDTH-1:0]   q_final;
    logic [WIDTH-1:0]   r_final;
    logic [WIDTH-1:0]   r_zero;

`ifdef SEQ_DIV_SIGNED_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;

    // MIN has no positive counterpart but its unsigned magnitude is exact,
    // so MIN / -1 naturally yields quotient MIN, remainder 0.
    assign dvd_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign dvs_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    assign q_final = qneg_q ? (~q_raw + 1'b1) : q_raw;
    assign r_final = rneg_q ? (~diff + 1'b1)  : diff;
    assign r_zero  = rneg_q ? (~stored_mag + 1'b1) : stored_mag;
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign q_final = q_raw;
    assign r_final = diff;
    assign r_zero  = stored_mag;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        qsh_d   = qsh_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rmdr_d  = rmdr_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    dvs_d = dvs_mag;
                    rem_d = {{WIDTH{1'b0}}, dvd_mag[WIDTH-1]};
                    qsh_d = {dvd_mag[WIDTH-2:0], 1'b0};
`ifdef SEQ_DIV_SIGNED_EN
                    qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    rneg_d = dividend[WIDTH-1];
`endif
                    if (divisor == '0) begin
                        state_d = S_ZERO;
                    end else begin
                        state_d = S_CALC;
                        dbz_d   = 1'b0;
                    end
                end
            end
            S_CALC: begin
                rem_d = {diff, qsh_q[WIDTH-1]};
                qsh_d = q_raw;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    quot_d  = q_final;
                    rmdr_d  = r_final;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ZERO: begin
                quot_d  = '1;
                rmdr_d  = r_zero;
                dbz_d   = 1'b1;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            qsh_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rmdr_q  <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            qsh_q   <= qsh_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rmdr_q  <= rmdr_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
`ifdef SEQ_DIV_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rmdr_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div (WIDTH=8): directed cases plus randomized
// operands compared with an arithmetic reference model.
module tb_seq_div;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;

    seq_div #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on the operand values.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
`ifdef SEQ_DIV_SIGNED_EN
            int ia;
            int ib;
            ia = $signed(a);
            ib = $signed(b);
            q  = W'(ia / ib);
            r  = W'(ia % ib);
`else
            q  = a / b;
            r  = a % b;
`endif
            z = 1'b0;
        end
    endfunction

    // Called at a negedge: presents a request, then follows it cycle by cycle
    // up to the expected done cycle, returning at the negedge where done is high.
    // poke_at>0 raises start with other operands during busy at that cycle.
    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input int poke_at,
                       output logic [W-1:0] eq, output logic [W-1:0] er, output logic ez);
        int lat;
        model(a, b, eq, er, ez);
        lat      = (b == '0) ? 2 : W + 1;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k < lat) begin
                check($sformatf("busy %0h/%0h c%0d", a, b, k), busy, 1);
                check($sformatf("done_early %0h/%0h c%0d", a, b, k), done, 0);
            end else begin
                check($sformatf("done %0h/%0h", a, b), done, 1);
                check($sformatf("busy_end %0h/%0h", a, b), busy, 0);
                check($sformatf("quot %0h/%0h", a, b), quotient, eq);
                check($sformatf("rem %0h/%0h", a, b), remainder, er);
                check($sformatf("dbz %0h/%0h", a, b), div_by_zero, ez);
            end
            if (k == poke_at) begin
                start    = 1'b1;
                dividend = 8'd50;
                divisor  = 8'd5;
            end else begin
                start    = 1'b0;
                dividend = W'($urandom);
                divisor  = W'($urandom);
            end
        end
    endtask

    // One cycle after a done: pulse gone, results held.
    task automatic after_done(input string tag, input logic [W-1:0] eq,
                              input logic [W-1:0] er, input logic ez);
        @(negedge clk);
        check({tag, " done_width"}, done, 0);
        check({tag, " idle"}, busy, 0);
        check({tag, " hold_q"}, quotient, eq);
        check({tag, " hold_r"}, remainder, er);
        check({tag, " hold_dbz"}, div_by_zero, ez);
    endtask

    initial begin
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset quot", quotient, 0);
        check("reset rem", remainder, 0);
        check("reset dbz", div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 100/7
        run(8'd100, 8'd7, 0, eq, er, ez);
        check("t1 q14", quotient, 8'd14);
        check("t1 r2", remainder, 8'd2);
        after_done("t1", eq, er, ez);

        // 255/1 then 0/5 issued in the done cycle
        run(8'd255, 8'd1, 0, eq, er, ez);
        check("t2 q255", quotient, 8'd255);
        run(8'd0, 8'd5, 0, eq, er, ez);
        check("t2 q0", quotient, 8'd0);
        check("t2 r0", remainder, 8'd0);
        after_done("t2", eq, er, ez);

        // divide by zero, then a normal division clears the flag
        run(8'd37, 8'd0, 0, eq, er, ez);
        check("t3 qff", quotient, 8'hFF);
        check("t3 r37", remainder, 8'd37);
        check("t3 dbz", div_by_zero, 1);
        after_done("t3z", eq, er, ez);
        run(8'd9, 8'd3, 0, eq, er, ez);
        check("t3 q3", quotient, 8'd3);
        check("t3 dbz_clr", div_by_zero, 0);
        after_done("t3", eq, er, ez);

        // start during busy is ignored
        run(8'd200, 8'd9, 3, eq, er, ez);
        check("t4 q22", quotient, 8'd22);
        check("t4 r2", remainder, 8'd2);
        after_done("t4", eq, er, ez);
        repeat (W + 2) begin
            @(negedge clk);
            check("t4 no_second_done", done, 0);
        end

        // reset in the middle of a division
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5 busy", busy, 0);
        check("t5 done", done, 0);
        check("t5 quot", quotient, 0);
        check("t5 rem", remainder, 0);
        check("t5 dbz", div_by_zero, 0);
        rst_n = 1'b1;
        repeat (W + 2) begin
            @(negedge clk);
            check("t5 no_done", done, 0);
        end
        run(8'd12, 8'd5, 0, eq, er, ez);
        check("t5 q2", quotient, 8'd2);
        check("t5 r2", remainder, 8'd2);
        after_done("t5", eq, er, ez);

`ifdef SEQ_DIV_SIGNED_EN
        run(8'hF9, 8'd2, 0, eq, er, ez);
        check("t6 -7/2 q", quotient, 8'hFD);
        check("t6 -7/2 r", remainder, 8'hFF);
        run(8'd7, 8'hFE, 0, eq, er, ez);
        check("t6 7/-2 q", quotient, 8'hFD);
        check("t6 7/-2 r", remainder, 8'd1);
        run(8'h80, 8'hFF, 0, eq, er, ez);
        check("t6 min/-1 q", quotient, 8'h80);
        check("t6 min/-1 r", remainder, 8'd0);
        check("t6 min/-1 dbz", div_by_zero, 0);
        after_done("t6", eq, er, ez);
`else
        run(8'hF9, 8'd2, 0, eq, er, ez);
        check("t6 q124", quotient, 8'd124);
        check("t6 r1", remainder, 8'd1);
        after_done("t6", eq, er, ez);
`endif

        // randomized operands, random gaps and back-to-back issues
        for (int n = 0; n < 60; n++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                2:       rb = W'($urandom_range(128, 255));
                default: rb = W'($urandom_range(1, 255));
            endcase
            run(ra, rb, 0, eq, er, ez);
            if ($urandom_range(0, 1) == 1)
                after_done("rand", eq, er, ez);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
